// File: rtl/icache_direct_mapped.sv
// Direct-mapped instruction cache, one 32-bit word per line, sitting between the
// fetcher and the memory controller's icache port. Misses are filled one word at a time.
module icache_direct_mapped #(
  parameter int ADDR_WIDTH = 17,
  parameter int INDEX_BITS = 8
) (
  input  logic        clockIn,
  input  logic        resetIn,
  input  logic        readyIn,
  input  logic        clearIn,
  input  logic        fetchFlag,
  input  logic [31:0] fetchPc,
  output logic        fetchOk,
  output logic [31:0] fetchInst,
  output logic        memFlag,
  output logic [31:0] memAddr,
  input  logic        memOk,
  input  logic [31:0] memData
);

  localparam int LINES    = 1 << INDEX_BITS;
  localparam int TAG_BITS = ADDR_WIDTH - INDEX_BITS - 2;

  // state    | meaning
  // S_IDLE   | waiting for a fetch; hits are answered from the arrays
  // S_MISS   | line fill outstanding at the controller, memAddr held
  typedef enum logic {S_IDLE, S_MISS} state_e;

  state_e              state_q, state_d;
  logic                ok_q, ok_d;
  logic [31:0]         inst_q, inst_d;
  logic [29:0]         miss_q, miss_d;
  logic [LINES-1:0]    valid_q;
  logic                fill_we;

  logic [TAG_BITS-1:0] tag_mem  [LINES];
  logic [31:0]         data_mem [LINES];

  logic [INDEX_BITS-1:0] fetch_idx, fill_idx;
  logic [TAG_BITS-1:0]   fetch_tag, fill_tag;
  logic                  hit;
  logic                  pc_unused;

  assign fetch_idx = fetchPc[INDEX_BITS+1:2];
  assign fetch_tag = fetchPc[ADDR_WIDTH-1:INDEX_BITS+2];
  assign fill_idx  = miss_q[INDEX_BITS-1:0];
  assign fill_tag  = miss_q[ADDR_WIDTH-3:INDEX_BITS];
  assign hit       = valid_q[fetch_idx] && (tag_mem[fetch_idx] == fetch_tag);
  assign pc_unused = ^fetchPc[1:0];

  // The controller samples memFlag while returning to idle, so it must drop on memOk.
  assign memFlag   = (state_q == S_MISS) & ~memOk & ~clearIn;
  assign memAddr   = {miss_q, 2'b00};
  assign fetchOk   = ok_q;
  assign fetchInst = inst_q;

  always_comb begin
    state_d = state_q;
    ok_d    = 1'b0;
    inst_d  = inst_q;
    miss_d  = miss_q;
    fill_we = 1'b0;
    if (clearIn) begin
      state_d = S_IDLE;
      // Fill data arriving with a clear is still correct; keep the line, drop the response.
      fill_we = (state_q == S_MISS) && memOk;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (fetchFlag && !ok_q) begin
            if (hit) begin
              ok_d   = 1'b1;
              inst_d = data_mem[fetch_idx];
            end else begin
              miss_d  = fetchPc[31:2];
              state_d = S_MISS;
            end
          end
        end
        S_MISS: begin
          if (memOk) begin
            fill_we = 1'b1;
            ok_d    = 1'b1;
            inst_d  = memData;
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clockIn or negedge resetIn) begin
    if (!resetIn) begin
      state_q <= S_IDLE;
      ok_q    <= 1'b0;
      inst_q  <= '0;
      miss_q  <= '0;
      valid_q <= '0;
    end else if (readyIn) begin
      state_q <= state_d;
      ok_q    <= ok_d;
      inst_q  <= inst_d;
      miss_q  <= miss_d;
      if (fill_we) valid_q[fill_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clockIn) begin
    if (readyIn && fill_we) begin
      tag_mem[fill_idx]  <= fill_tag;
      data_mem[fill_idx] <= memData;
    end
  end

endmodule

// File: tb/tb_icache_direct_mapped.sv
// Bench for icache_direct_mapped: directed scenarios plus randomized fetches
// checked against a line-table reference model.
module tb_icache_direct_mapped;

  logic        clockIn = 1'b0;
  logic        resetIn = 1'b0;
  logic        readyIn = 1'b1;
  logic        clearIn = 1'b0;
  logic        fetchFlag = 1'b0;
  logic [31:0] fetchPc = '0;
  logic        memOk = 1'b0;
  logic [31:0] memData = '0;
  logic        fetchOk;
  logic [31:0] fetchInst;
  logic        memFlag;
  logic [31:0] memAddr;

  icache_direct_mapped dut (
    .clockIn  (clockIn),
    .resetIn  (resetIn),
    .readyIn  (readyIn),
    .clearIn  (clearIn),
    .fetchFlag(fetchFlag),
    .fetchPc  (fetchPc),
    .fetchOk  (fetchOk),
    .fetchInst(fetchInst),
    .memFlag  (memFlag),
    .memAddr  (memAddr),
    .memOk    (memOk),
    .memData  (memData)
  );

  always #5 clockIn = ~clockIn;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: per line, is it present, which tag, which word.
  bit          m_valid [256];
  int unsigned m_tag   [256];
  logic [31:0] m_data  [256];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clockIn);
    #1;
  endtask

  function automatic int unsigned idx_of(input logic [31:0] pc);
    return (pc / 4) % 256;
  endfunction

  function automatic int unsigned tag_of(input logic [31:0] pc);
    return (pc / 1024) % 128;
  endfunction

  function automatic bit model_hit(input logic [31:0] pc);
    return m_valid[idx_of(pc)] && (m_tag[idx_of(pc)] == tag_of(pc));
  endfunction

  task automatic model_fill(input logic [31:0] pc, input logic [31:0] d);
    m_valid[idx_of(pc)] = 1'b1;
    m_tag[idx_of(pc)]   = tag_of(pc);
    m_data[idx_of(pc)]  = d;
  endtask

  // clr_mode: 0 normal fill, 1 clear mid-miss, 2 clear coinciding with memOk
  task automatic fetch(input logic [31:0] pc, input logic [31:0] d, input int waitc,
                       input int stallc, input int clr_mode);
    logic [31:0] exp_addr;
    exp_addr  = pc & 32'hFFFF_FFFC;
    fetchFlag = 1'b0;
    tick();
    fetchFlag = 1'b1;
    fetchPc   = pc;
    if (model_hit(pc)) begin
      tick();
      fetchFlag = 1'b0;
      chk("hit_ok", fetchOk, 1);
      chk("hit_inst", fetchInst, m_data[idx_of(pc)]);
      chk("hit_noflag", memFlag, 0);
      return;
    end
    tick();
    fetchFlag = 1'b0;
    fetchPc   = $urandom;
    chk("miss_ok", fetchOk, 0);
    chk("miss_flag", memFlag, 1);
    chk("miss_addr", memAddr, exp_addr);
    for (int i = 0; i < waitc; i++) begin
      tick();
      chk("wait_flag", memFlag, 1);
      chk("wait_addr", memAddr, exp_addr);
    end
    if (clr_mode == 1) begin
      clearIn = 1'b1;
      #1 chk("clr_flag", memFlag, 0);
      tick();
      clearIn = 1'b0;
      chk("clr_ok", fetchOk, 0);
      chk("clr_idle", memFlag, 0);
      return;
    end
    memOk   = 1'b1;
    memData = d;
    if (clr_mode == 2) begin
      clearIn = 1'b1;
      #1 chk("clrok_flag", memFlag, 0);
      tick();
      clearIn = 1'b0;
      memOk   = 1'b0;
      chk("clrok_ok", fetchOk, 0);
      model_fill(pc, d);
      return;
    end
    readyIn = 1'b0;
    for (int i = 0; i < stallc; i++) begin
      #1 chk("stall_flag", memFlag, 0);
      tick();
      chk("stall_ok", fetchOk, 0);
      chk("stall_addr", memAddr, exp_addr);
    end
    readyIn = 1'b1;
    #1 chk("memok_flag", memFlag, 0);
    tick();
    memOk   = 1'b0;
    memData = $urandom;
    chk("fill_ok", fetchOk, 1);
    chk("fill_inst", fetchInst, d);
    model_fill(pc, d);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) m_valid[i] = 1'b0;
    #12;
    chk("rst_ok", fetchOk, 0);
    chk("rst_inst", fetchInst, 0);
    chk("rst_addr", memAddr, 0);
    chk("rst_flag", memFlag, 0);
    resetIn = 1'b1;
    tick();

    fetch(32'h100, 32'h0050_0093, 3, 0, 0);
    fetch(32'h100, 32'h0, 0, 0, 0);
    chk("rehit_ok", fetchOk, 1);
    fetchFlag = 1'b1;
    fetchPc   = 32'h100;
    tick();
    chk("b2b_bubble", fetchOk, 0);
    tick();
    chk("b2b_ok", fetchOk, 1);
    chk("b2b_inst", fetchInst, 32'h0050_0093);
    fetchFlag = 1'b0;

    fetch(32'h500, 32'h1234_5678, 2, 0, 0);
    fetch(32'h100, 32'h0050_0093, 1, 0, 0);
    chk("conflict_model", {31'b0, model_hit(32'h500)}, 0);

    fetch(32'h200, 32'h0, 2, 0, 1);
    fetch(32'h200, 32'hCAFE_F00D, 1, 0, 0);
    fetch(32'h600, 32'hDEAD_BEEF, 1, 3, 0);

    fetchFlag = 1'b0;
    tick();
    fetchFlag = 1'b1;
    fetchPc   = 32'h100;
    clearIn   = 1'b1;
    tick();
    clearIn   = 1'b0;
    fetchFlag = 1'b0;
    chk("idle_clr_ok", fetchOk, 0);
    chk("idle_clr_flag", memFlag, 0);

    memOk = 1'b1;
    memData = 32'h5555_AAAA;
    tick();
    memOk = 1'b0;
    chk("idle_memok_ok", fetchOk, 0);
    chk("idle_memok_flag", memFlag, 0);

    tick();
    fetchFlag = 1'b1;
    fetchPc   = 32'h300;
    tick();
    fetchFlag = 1'b0;
    chk("rst_miss_flag", memFlag, 1);
    #2 resetIn = 1'b0;
    #1;
    chk("async_flag", memFlag, 0);
    chk("async_ok", fetchOk, 0);
    chk("async_addr", memAddr, 0);
    for (int i = 0; i < 256; i++) m_valid[i] = 1'b0;
    #3 resetIn = 1'b1;
    tick();
    fetch(32'h100, 32'h0050_0093, 0, 0, 0);

    for (int n = 0; n < 300; n++) begin
      logic [31:0] pc;
      int r;
      pc = ($urandom_range(0, 3) << 28) | ($urandom_range(0, 2) << 10) |
           ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
      r  = $urandom_range(0, 9);
      fetch(pc, $urandom, $urandom_range(0, 4), (r > 7) ? $urandom_range(1, 3) : 0,
            (r == 0) ? 1 : ((r == 1) ? 2 : 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/icache_direct_mapped.md
Name: icache_direct_mapped

Overview:
- Direct-mapped instruction cache between the instruction fetcher and the memory controller's icache port.
- Acts as the initiator on the controller's icache interface: drives the request flag and address, and consumes the one-cycle ok pulse together with the 32-bit word.
- Serves hits from on-chip arrays and fills one-word lines on a miss.
- Obeys the global readyIn stall and clearIn (branch mispredict) abort.

Parameters:
ADDR_WIDTH, 17, RAM address bits used for the tag, matching the memory controller.
INDEX_BITS, 8, log2 of line count; one 32-bit word per line (256 lines default).

Ports:
clockIn  input  1  system clock, posedge.
resetIn  input  1  asynchronous, active-low reset.
readyIn  input  1  global enable; low freezes all sequential state.
clearIn  input  1  mispredict flush of the in-flight fetch.
fetchFlag  input  1  fetcher request valid.
fetchPc  input  32  requested instruction address; bits [1:0] ignored.
fetchOk  output  1  one-cycle response pulse.
fetchInst  output  32  instruction word; valid while fetchOk=1, held otherwise.
memFlag  output  1  request to the memory controller (its icacheFlag).
memAddr  output  32  word-aligned miss address (its icacheAddr).
memOk  input  1  controller word-ready pulse (its icacheOk).
memData  input  32  controller assembled word; valid when memOk=1.

Behaviour:
- Interface decision: one clock; reset is asynchronous and active-low.
- Reset (resetIn=0, asynchronous):
  - state=IDLE; all valid bits cleared.
  - fetchOk=0, fetchInst=0, memAddr=0, memFlag=0.
  - Tag and data arrays are not reset.
- Address split:
  - index = pc[INDEX_BITS+1:2].
  - tag = pc[ADDR_WIDTH-1:INDEX_BITS+2].
  - pc bits above ADDR_WIDTH-1 are ignored.
- All register updates below require readyIn=1. With readyIn=0, state, fetchOk, fetchInst and the arrays hold.
- fetchOk defaults to 0 every enabled cycle unless set below. It is a pulse, never held.
- IDLE:
  - A request is accepted when fetchFlag=1 and fetchOk=0. This leaves one bubble after each response, so the fetcher may change fetchPc on fetchOk.
  - Hit (valid & tag match): next edge fetchOk<=1, fetchInst<=data[index]; stay in IDLE. Hit latency is 1 cycle.
  - Miss: latch missAddr<={fetchPc[31:2],2'b00}; go to MISS.
- MISS:
  - memFlag = (state==MISS) & ~memOk & ~clearIn, combinational.
  - memAddr = missAddr, held stable for the whole miss. The controller re-reads it each byte cycle.
  - memFlag must be low in the memOk cycle, because the controller samples the flag while returning to its IDLE.
  - memOk=1 & clearIn=0: write data/tag/valid at missAddr's index; fetchOk<=1; fetchInst<=memData; go to IDLE. Miss-to-response latency is 1 cycle after memOk.
  - fetchFlag and fetchPc are ignored during MISS.
- clearIn=1 with readyIn=1, any state:
  - Next state is IDLE; fetchOk<=0; memFlag drops in the same cycle.
  - A request presented in that cycle is not accepted.
  - If memOk=1 coincides with clearIn: the line is still written (the data is correct), but no fetchOk is issued.
- A memOk seen while in IDLE is ignored; the controller never issues a stale ok after a clear.
- The controller may be serving an LSB access first (LSB priority). memFlag simply stays high until memOk.
- Asynchronous reset mid-MISS: memFlag drops immediately. The controller's own reset covers its side.

Test Plan:
- Reset, fetchPc=0x100 with fetchFlag -> next cycle memFlag=1, memAddr=0x100; after 4 cycles drive memOk=1, memData=0x00500093 -> memFlag=0 in that cycle; next cycle fetchOk=1, fetchInst=0x00500093.
- Fetch 0x100 again -> fetchOk=1 one cycle later with 0x00500093; memFlag never asserts. A back-to-back request in the fetchOk cycle is accepted only after the bubble.
- Conflict: fetch 0x500 (same index 0x40, different tag) -> miss, fill 0x12345678. Then fetch 0x100 -> miss again, memAddr=0x100.
- Fetch 0x200 (miss), assert clearIn for 1 cycle mid-miss -> memFlag=0 that cycle; IDLE next; no fetchOk. A later fetch of 0x200 misses again.
- Miss pending, readyIn=0 for 3 cycles while memOk=1, memData=0xDEADBEEF -> no state or output change. On readyIn=1, fetchOk=1 with 0xDEADBEEF the next cycle.
- Fill 0x100, then pulse resetIn low asynchronously mid-miss on 0x300 -> memFlag and fetchOk fall without a clock edge. After release, fetch 0x100 misses (valid bits cleared).
